// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared window geometry, pixel width and window-producer state encoding
package maxpool_pkg;
  localparam int KERNEL_SIZE = 2;
  localparam int DATA_WIDTH = 16;
  typedef enum logic [1:0] {ROW_TOP, ROW_BOTTOM, ROW_SKIP} mp_win_state_t;
endpackage

// File: rtl/maxpool_line_buf.sv
// maxpool_line_buf: one-row pixel buffer, single write port, two async read ports
module maxpool_line_buf #(
  parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH = 64,
  parameter int AW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr_prev,
  input  logic [AW-1:0]         raddr_cur,
  output logic [DATA_WIDTH-1:0] rdata_prev,
  output logic [DATA_WIDTH-1:0] rdata_cur
);
  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata_prev = mem[raddr_prev];
  assign rdata_cur = mem[raddr_cur];
endmodule

// File: rtl/maxpool_window_fifo.sv
// maxpool_window_fifo: turns a raster pixel stream into stride-2 2x2 windows for the maxpool pipeline
module maxpool_window_fifo #(
  parameter int KERNEL_SIZE = maxpool_pkg::KERNEL_SIZE,
  parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                pixel_valid,
  input  logic [DATA_WIDTH-1:0]                               pixel_in,
  output logic                                                maxpool_en_maxfifo,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_maxfifo,
  output logic                                                frame_done
);
  import maxpool_pkg::*;
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  // last bottom row of a complete row pair; an odd trailing row is skipped
  localparam logic [RW-1:0] PAIR_LAST = RW'(IMG_HEIGHT - IMG_HEIGHT % 2 - 1);
  if (KERNEL_SIZE != 2) begin : g_bad_kernel
    $error("maxpool_window_fifo supports only KERNEL_SIZE == 2");
  end
  mp_win_state_t state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [DATA_WIDTH-1:0] hold_px, lb_prev, lb_cur;
  logic last_col, last_row, top_wr, win_fire;
  assign last_col = col_cnt == COL_LAST;
  assign last_row = row_cnt == ROW_LAST;
  assign top_wr = pixel_valid && state == ROW_TOP;
  assign win_fire = pixel_valid && state == ROW_BOTTOM && col_cnt[0];
  maxpool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_WIDTH (IMG_WIDTH),
    .AW        (CW)
  ) u_line_buf (
    .clk       (clk),
    .we        (top_wr),
    .waddr     (col_cnt),
    .wdata     (pixel_in),
    .raddr_prev(col_cnt - 1'b1),
    .raddr_cur (col_cnt),
    .rdata_prev(lb_prev),
    .rdata_cur (lb_cur)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ROW_TOP;
      col_cnt <= '0;
      row_cnt <= '0;
      hold_px <= '0;
      maxpool_en_maxfifo <= 1'b0;
      frame_done <= 1'b0;
      window_maxfifo <= '0;
    end else begin
      maxpool_en_maxfifo <= win_fire;
      frame_done <= pixel_valid && last_col && last_row;
      if (win_fire) begin
        window_maxfifo[0][0] <= lb_prev;
        window_maxfifo[0][1] <= lb_cur;
        window_maxfifo[1][0] <= hold_px;
        window_maxfifo[1][1] <= pixel_in;
      end
      if (pixel_valid) begin
        if (state == ROW_BOTTOM && !col_cnt[0]) hold_px <= pixel_in;
        col_cnt <= last_col ? '0 : col_cnt + 1'b1;
        if (last_col) begin
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
          state <= last_row ? ROW_TOP :
                   state == ROW_TOP ? ROW_BOTTOM :
                   row_cnt == PAIR_LAST ? ROW_SKIP : ROW_TOP;
        end
      end
    end
endmodule
